s_spi_slave: RTL

S_SPI_SLAVE -- requirements
Module: s_spi_slave

---
 rtl/s_spi_slave.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/s_spi_slave.sv
// Mode-0 SPI slave, oversampled by I_CLK: 2-flop synchronizers and edge detect,
// a one-deep TX buffer feeding the shifter, and a level-style RX handshake.
module s_spi_slave #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  I_CLK,
    input  logic                  I_RESETN,
    input  logic                  SCLK,
    input  logic                  SS_N,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic                  MISO_OE,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ack,
    input  logic                  err_clr,
    output logic                  rx_overrun,
    output logic                  tx_underrun
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_WIDTH);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic                  sclk_s1_q, sclk_s2_q, sclk_d_q;
    logic                  ss_s1_q, ss_s2_q, ss_d_q;
    logic                  mosi_s1_q, mosi_s2_q;
    logic [1:0]            flush_q;
    logic                  armed_q;

    logic [0:0]            state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic                  buf_full_q, buf_full_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  overrun_q, overrun_d;
    logic                  underrun_q, underrun_d;

    logic                  sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic                  consume, complete;
    logic                  overrun_set, underrun_set;

    assign sclk_rise = sclk_s2_q & ~sclk_d_q;
    assign sclk_fall = ~sclk_s2_q & sclk_d_q;
    assign ss_fall   = ~ss_s2_q & ss_d_q;
    assign ss_rise   = ss_s2_q & ~ss_d_q;

    // The select synchronizer resets to "deselected", so a master already holding
    // SS_N low at reset release would look like a fresh falling edge. armed_q only
    // rises once the flushed synchronizer has really seen SS_N high.
    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge I_CLK or negedge I_RESETN) begin
        if (!I_RESETN) begin
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_d_q  <= 1'b0;
            ss_s1_q   <= 1'b1;
            ss_s2_q   <= 1'b1;
            ss_d_q    <= 1'b1;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
            flush_q   <= 2'd0;
            armed_q   <= 1'b0;
        end else begin
            sclk_s1_q <= SCLK;
            sclk_s2_q <= sclk_s1_q;
            sclk_d_q  <= sclk_s2_q;
            ss_s1_q   <= SS_N;
            ss_s2_q   <= ss_s1_q;
            ss_d_q    <= ss_s2_q;
            mosi_s1_q <= MOSI;
            mosi_s2_q <= mosi_s1_q;
            if (flush_q != 2'd3) flush_q <= flush_q + 2'd1;
            armed_q   <= armed_q | ((flush_q == 2'd3) & ss_s2_q);
        end
    end

    // NOTE: every signal assigned here gets its default first, so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        tx_shift_d   = tx_shift_q;
        rx_shift_d   = rx_shift_q;
        buf_d        = buf_q;
        buf_full_d   = buf_full_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        consume      = 1'b0;
        complete     = 1'b0;
        overrun_set  = 1'b0;
        underrun_set = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ss_fall && armed_q) begin
                    state_d   = ST_ACTIVE;
                    bit_cnt_d = '0;
                    consume   = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (ss_rise) begin
                    state_d    = ST_IDLE;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s2_q};
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    complete   = (bit_cnt_q == LAST_BIT);
                end else if (sclk_fall) begin
                    if (bit_cnt_q == FULL_CNT) begin
                        bit_cnt_d = '0;
                        consume   = 1'b1;
                    end else begin
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A load landing on the consume cycle goes straight to the shifter.
        if (consume) begin
            tx_shift_d   = tx_load ? tx_data : (buf_full_q ? buf_q : '0);
            buf_full_d   = 1'b0;
            underrun_set = ~tx_load & ~buf_full_q;
        end else if (tx_load) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end

        if (complete) begin
            rx_data_d   = {rx_shift_q[DATA_WIDTH-2:0], mosi_s2_q};
            rx_valid_d  = 1'b1;
            overrun_set = rx_valid_q & ~rx_ack;
        end else if (rx_ack) begin
            rx_valid_d = 1'b0;
        end

        overrun_d  = overrun_set | (overrun_q & ~err_clr);
        underrun_d = underrun_set | (underrun_q & ~err_clr);
    end

    // NOTE: the TX buffer and shifters are plain registers, so they take the async reset too.
    always_ff @(posedge I_CLK or negedge I_RESETN) begin
        if (!I_RESETN) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
        end
    end

    assign MISO        = (state_q == ST_ACTIVE) & tx_shift_q[DATA_WIDTH-1];
    assign MISO_OE     = (state_q == ST_ACTIVE);
    assign tx_ready    = ~buf_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_overrun  = overrun_q;
    assign tx_underrun = underrun_q;

endmodule
